// File: rtl/ara_perf_pkg.sv
// Shared types and constants for the Ara runtime / stall performance monitor.
package ara_perf_pkg;

    localparam int unsigned PerfCntWidth = 64;
    localparam int unsigned PerfNrEvents = 3;

    typedef logic [PerfCntWidth-1:0] perf_cnt_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mon_state_e;

    // Event strobe positions within event_i.
    localparam int unsigned EvDcacheStall = 0;
    localparam int unsigned EvIcacheStall = 1;
    localparam int unsigned EvSbFull      = 2;

    // Read index of the runtime buffer; event k is read at index k+1.
    localparam int unsigned RdIdxRuntime  = 0;

endpackage

// File: rtl/ara_runtime_monitor_sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned Width = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    // Next count: clear wins, otherwise increment unless already saturated.
    // NOTE: assign every always_comb output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + Width'(1);
        end
    end

    // Count register with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/ara_runtime_monitor.sv
// Runtime and stall-event monitor for Ara: opens a counting window on the first
// vector dispatch, snapshots all counters into readable buffers when Ara drains.
module ara_runtime_monitor
    import ara_perf_pkg::*;
#(
    parameter int unsigned NrEvents = PerfNrEvents,
    parameter int unsigned CntWidth = PerfCntWidth,
    localparam int unsigned IdxWidth = $clog2(NrEvents + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cnt_en_i,
    input  logic                req_valid_i,
    input  logic                ara_idle_i,
    input  logic [NrEvents-1:0] event_i,
    input  logic                clr_i,
    input  logic                rd_req_i,
    input  logic [IdxWidth-1:0] rd_idx_i,
    output logic                rd_valid_o,
    output logic [CntWidth-1:0] rd_data_o,
    output logic                running_o,
    output logic                snap_o
);

    localparam int unsigned NrCnt = NrEvents + 1;

    mon_state_e          state_q, state_d;
    logic                pending_q, pending_d;
    logic                snap_q;
    logic                snap_take;
    logic                rd_valid_q;
    logic [CntWidth-1:0] rd_data_q, rd_data_d;
    logic                run;
    logic [NrCnt-1:0]    inc;
    logic [CntWidth-1:0] cnt   [NrCnt];
    logic [CntWidth-1:0] buf_q [NrCnt];

    // Counting follows the registered state, so the first increment lands the
    // cycle after IDLE->RUN.
    assign run = (state_q == RUN);
    assign inc = {event_i & {NrEvents{run}}, run};

    // Slot RdIdxRuntime counts window cycles, slot k+1 counts event k.
    for (genvar k = 0; k < NrCnt; k++) begin : g_cnt
        sat_counter #(
            .Width (CntWidth)
        ) u_cnt (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clr_i   (clr_i),
            .inc_i   (inc[k]),
            .count_o (cnt[k])
        );
    end

    // Window FSM: enter on an enabled dispatch, leave once disabled and drained.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cnt_en_i && req_valid_i)  state_d = RUN;
            RUN:     if (!cnt_en_i && ara_idle_i)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clr_i) begin
            state_d = IDLE;
        end
    end

    // Snapshot once Ara drains after any dispatch; a new dispatch in the idle
    // cycle defers it. Pending tracks dispatches regardless of the window.
    assign snap_take = pending_q && ara_idle_i && !req_valid_i && !clr_i;

    always_comb begin
        pending_d = pending_q | req_valid_i;
        if (clr_i || snap_take) begin
            pending_d = 1'b0;
        end
    end

    // Read mux: buffers are read before this edge's snapshot or clear lands.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_req_i) begin
            rd_data_d = (32'(rd_idx_i) <= NrEvents) ? buf_q[rd_idx_i] : '0;
        end
    end

    // Snapshot buffers, cleared by reset or clr_i.
    // NOTE: these buffers are few and software-visible, so they are reset like ordinary flops rather than left as an unreset RAM.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            for (int i = 0; i < NrCnt; i++) begin
                buf_q[i] <= '0;
            end
        end else if (snap_take) begin
            for (int i = 0; i < NrCnt; i++) begin
                buf_q[i] <= cnt[i];
            end
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            snap_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            snap_q     <= snap_take;
            rd_valid_q <= rd_req_i;
            rd_data_q  <= rd_data_d;
        end
    end

    assign running_o  = run;
    assign snap_o     = snap_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;

endmodule
